// File: rtl/apb_bridge_pkg.sv
// Shared types and response codes for the AXI4-Lite-to-APB3 bridge.
// The AXI front end imports the same RESP_* constants.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB ACCESS phase: clear, increment, and a
// terminal flag raised when the count reaches TIMEOUT-1.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(TIMEOUT)-1:0] count,
  output logic                       terminal
);

  localparam int CW = $clog2(TIMEOUT);

  assign terminal = (count == CW'(TIMEOUT - 1));

  // Saturates at the terminal count; the master aborts there anyway.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !terminal) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb3_master.sv
// APB3 master stage of the bridge: one request at a time, SETUP/ACCESS
// transfer with PREADY wait states, PSLVERR and a bounded wait timeout.
module apb3_master
  import apb_bridge_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDRESS-1:0]    REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [1:0]            RSP_RESP,
  output logic [ADDRESS-1:0]    PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output apb_state_t            dbg_state
);

  // Handshake rule on both ports: a transfer happens on the rising ACLK edge
  // where valid and ready are both high; valid never waits on ready, and
  // REQ_READY/RSP_VALID are pure state decodes with no input dependency.

  apb_state_t                   state;
  logic                         wait_clear;
  logic                         wait_inc;
  logic                         wait_tc;
  logic [$clog2(TIMEOUT)-1:0]   wait_count;

  assign REQ_READY = (state == IDLE);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign RSP_VALID = (state == RESP);
  assign dbg_state = state;

  assign wait_clear = (state == SETUP);
  assign wait_inc   = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .clear    (wait_clear),
    .inc      (wait_inc),
    .count    (wait_count),
    .terminal (wait_tc)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      RSP_RDATA <= '0;
      RSP_RESP  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            PADDR  <= REQ_ADDR;
            PWRITE <= REQ_WRITE;
            PWDATA <= REQ_WRITE ? REQ_WDATA : '0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          // A completion on the terminal-count cycle beats the timeout.
          if (PREADY) begin
            RSP_RESP  <= PSLVERR ? RESP_SLVERR : RESP_OKAY;
            RSP_RDATA <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state     <= RESP;
          end else if (wait_tc) begin
            RSP_RESP  <= RESP_SLVERR;
            RSP_RDATA <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_RESP  <= RESP_OKAY;
            RSP_RDATA <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_master.sv
// Directed and randomized bench for apb3_master with an APB slave driver
// and a transaction-level response model.
module tb_apb3_master;
  import apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [DW-1:0] RSP_RDATA;
  logic [1:0]    RSP_RESP;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;
  apb_state_t    dbg_state;

  int n_checks = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];

  // Clock and reset
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  apb3_master #(
    .ADDRESS    (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_RESP  (RSP_RESP),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: a slave that stalls `waits` ACCESS cycles before PREADY.
  function automatic logic [DW+1:0] model_rsp(input logic wr, input int waits,
                                              input logic err, input logic [DW-1:0] rd);
    logic [DW-1:0] zero;
    zero = '0;
    if (waits >= TO) return {RESP_SLVERR, zero};
    if (err)         return {RESP_SLVERR, zero};
    return {RESP_OKAY, wr ? zero : rd};
  endfunction

  function automatic int model_access(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  // Driver: one full request/response; entry point is any cycle with the DUT idle.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic err, input logic [DW-1:0] rd,
                         input int hold, input logic req_in_hold);
    int acc;
    int rsp_c;
    bit seen;
    logic [DW+1:0] exp_v;
    logic [DW-1:0] exp_pwdata;
    exp_q.push_back(model_rsp(wr, waits, err, rd));
    exp_pwdata = wr ? wdata : '0;
    @(negedge ACLK);
    chk("idle_ready", {RSP_VALID, REQ_READY, PSEL}, 3'b010);
    REQ_VALID = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    @(posedge ACLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'($urandom_range(0, 1));
    REQ_ADDR  = $urandom;
    REQ_WDATA = $urandom;
    acc = 0;
    rsp_c = 0;
    seen = 0;
    for (int c = 1; c <= TO + 8 && !seen; c++) begin
      @(negedge ACLK);
      if (RSP_VALID) begin
        seen = 1;
        rsp_c = c;
        PREADY = 1'b0;
        PSLVERR = 1'b0;
      end else begin
        if (c == 1) chk("setup_phase", {PSEL, PENABLE, REQ_READY}, 3'b100);
        chk("psel_active", PSEL, 1'b1);
        chk("apb_bus", {PADDR, PWRITE, PWDATA}, {addr, wr, exp_pwdata});
        if (PSEL && PENABLE) begin
          acc++;
          PREADY  = (acc - 1 == waits);
          PSLVERR = PREADY ? err : 1'($urandom_range(0, 1));
          PRDATA  = PREADY ? rd : $urandom;
        end else begin
          PREADY = 1'b0;
          PSLVERR = 1'b0;
        end
      end
    end
    chk("rsp_seen", seen, 1'b1);
    chk("access_cycles", acc, model_access(waits));
    chk("rsp_cycle", rsp_c, 2 + model_access(waits));
    exp_v = exp_q.pop_front();
    chk("rsp_data", {RSP_RESP, RSP_RDATA}, exp_v);
    chk("rsp_psel", {PSEL, PENABLE, REQ_READY}, 3'b000);
    REQ_VALID = req_in_hold;
    for (int h = 0; h < hold; h++) begin
      @(negedge ACLK);
      chk("hold_valid", {RSP_VALID, REQ_READY, PSEL}, 3'b100);
      chk("hold_data", {RSP_RESP, RSP_RDATA}, exp_v);
    end
    RSP_READY = 1'b1;
    @(posedge ACLK);
    #1;
    RSP_READY = 1'b0;
    REQ_VALID = 1'b0;
  endtask

  initial begin
    logic wr;
    int waits;
    logic err;
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("reset_ctrl", {REQ_READY, RSP_VALID, PSEL, PENABLE, PWRITE}, 5'b10000);
    chk("reset_data", {RSP_RDATA, RSP_RESP, PADDR, PWDATA}, '0);
    chk("reset_state", dbg_state, IDLE);
    chk("reset_timer", dut.wait_count, '0);
    ARESET = 1'b0;

    // Directed cases
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0004, 32'h1111_2222, 3, 1'b0, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0008, 32'h0,         0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
    run_txn(1'b0, 32'h0000_000C, 32'h0,       100, 1'b0, 32'h5555_AAAA, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, TO - 1, 1'b0, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0024, 32'h0,    TO - 1, 1'b0, 32'h7777_8888, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0028, 32'h0,        TO, 1'b0, 32'h7777_8888, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0030, 32'h0BAD_0BAD, 1, 1'b1, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 32'h0,         2, 1'b0, 32'h0102_0304, 5, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      wr    = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 20);
      err   = ($urandom_range(0, 3) == 0);
      run_txn(wr, $urandom, $urandom, waits, err, $urandom, $urandom_range(0, 3), 1'b0);
    end

    // Asynchronous reset in the middle of an ACCESS wait
    @(negedge ACLK);
    REQ_VALID = 1'b1;
    REQ_WRITE = 1'b0;
    REQ_ADDR  = 32'h0000_0050;
    @(posedge ACLK);
    #1;
    REQ_VALID = 1'b0;
    PREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    ARESET = 1'b1;
    #1;
    chk("async_reset_ctrl", {PSEL, PENABLE, RSP_VALID, REQ_READY}, 4'b0001);
    chk("async_reset_bus", {PADDR, PWDATA, PWRITE}, '0);
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      @(negedge ACLK);
      chk("post_reset_quiet", {RSP_VALID, PSEL, REQ_READY}, 3'b001);
    end
    run_txn(1'b0, 32'h0000_0060, 32'h0, 0, 1'b0, 32'h9ABC_DEF0, 0, 1'b0);

    @(negedge ACLK);
    chk("final_idle", {REQ_READY, RSP_VALID, PSEL}, 3'b100);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
